adder_nibble_seq: RTL and testbench
===================================

Name: adder_nibble_seq

Overview:
- Sequencer sitting directly upstream and downstream of the 4-bit ripple-carry adder stage.
- Accepts one WIDTH-bit addition per transaction and drives the 4-bit adder one nibble per cycle, LSB nibble first.
- Feeds the adder's carry-out back as the next nibble's carry-in, and collects the 5-bit adder result into a WIDTH+1-bit sum.
- Trades latency for area: one small adder serves any operand width. Valid/ready handshakes on both the operand and result sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  transaction carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH+1  {carry, sum}.
- nib_a  output  4  current nibble of A to the 4-bit adder.
- nib_b  output  4  current nibble of B to the 4-bit adder.
- nib_cin  output  1  carry-in to the 4-bit adder.
- nib_res  input  5  adder result {cout, sum[3:0]}; combinational from nib_*.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE from any state, including mid-RUN or DONE.
  - out_valid=0, in_ready=1, out_sum=0, nibble index=0, carry register=0.
  - In-flight transaction is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a, in_b; carry register <= in_cin; index <= 0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - nib_a = a_reg[4*idx+3:4*idx], nib_b = b_reg[4*idx+3:4*idx], nib_cin = carry register.
  - Each cycle: sum_reg[4*idx+3:4*idx] <= nib_res[3:0]; carry register <= nib_res[4]; idx <= idx+1.
  - When idx==NIB-1: go to DONE; out_sum <= {nib_res[4], assembled sum}.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum stable until out_valid&&out_ready.
  - On the handshake: out_valid <= 0, go to IDLE.
  - No same-cycle acceptance of a new transaction. Next accept is possible the cycle after return to IDLE.
- Outside RUN: nib_a=0, nib_b=0, nib_cin=0.
- Latency:
  - Input handshake at edge k.
  - RUN occupies cycles k+1 .. k+NIB.
  - out_valid is high from cycle k+NIB+1.
  - Throughput is one result per NIB+2 cycles when out_ready is held high.
- Arithmetic: out_sum = in_a + in_b + in_cin, unsigned, WIDTH+1 bits; no overflow is possible.
- Boundary conditions:
  - in_valid while busy is ignored; operands are not sampled and no error is flagged.
  - out_ready while out_valid=0 has no effect.
  - in_a/in_b changing after acceptance does not affect the result.
  - WIDTH=4: a single RUN cycle.
  - idx is never out of range and wraps to 0 only on a new acceptance.

Test Plan (WIDTH=16 unless noted):
- Basic add: in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x05555. out_valid rises exactly 5 cycles after the accept edge. nib_a sequence is 4,3,2,1.
- Full ripple: 0xFFFF+0x0001, cin=0 -> out_sum=0x10000. nib_cin sequence is 0,1,1,1.
- Max operands: 0xFFFF+0xFFFF, cin=1 -> out_sum=0x1FFFF.
- Backpressure and busy input: hold out_ready=0 for 6 cycles after out_valid. Required: out_sum stable and in_ready=0 throughout. A new in_valid during RUN/DONE is ignored; the next transaction is taken only after return to IDLE.
- Reset mid-RUN: assert rst during the 2nd RUN cycle. Next cycle: in_ready=1, out_valid=0, out_sum=0. A new transaction 0x00FF+0x0001 then gives 0x00100.
- WIDTH=4 build: 0xF+0x1, cin=1 -> out_sum=0x11, out_valid 2 cycles after accept.

Source files
------------

// File: rtl/adder_nibble_seq_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface adder_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    // Requester side: issues operands, consumes results.
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum
    );

    // Sequencer side: accepts operands, produces results.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/adder_nibble_seq.sv
// Drives an external 4-bit ripple adder one nibble per cycle (LSB first) to build a WIDTH-bit sum.
// Latency: accept at edge k, RUN for NIB cycles, out_valid from cycle k+NIB+1; one result per NIB+2 cycles.
// Backpressure: result held in DONE until out_ready; operands refused (in_ready=0) while busy.
module adder_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_nibble_seq_if.slave    io,
    output logic [3:0]           nib_a,
    output logic [3:0]           nib_b,
    output logic                 nib_cin,
    input  logic [4:0]           nib_res
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH:0]   out_sum_r;
    int               base;

    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.out_sum   = out_sum_r;

    // Select the current nibble for the adder and merge its result into the partial sum.
    always_comb begin
        base     = 4 * int'(idx);
        nib_a    = 4'h0;
        nib_b    = 4'h0;
        nib_cin  = 1'b0;
        sum_next = sum_reg;
        if (state == RUN) begin
            nib_a   = a_reg[base +: 4];
            nib_b   = b_reg[base +: 4];
            nib_cin = carry;
        end
        sum_next[base +: 4] = nib_res[3:0];
    end

    // Sequencer FSM: capture operands, step through nibbles, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid && in_ready_r) begin
                        a_reg      <= io.in_a;
                        b_reg      <= io.in_b;
                        sum_reg    <= '0;
                        carry      <= io.in_cin;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg <= sum_next;
                    carry   <= nib_res[4];
                    if (idx == LAST_IDX) begin
                        // idx parks on the last nibble; it only restarts on a new accept.
                        out_sum_r   <= {nib_res[4], sum_next};
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready rises only after the return to IDLE, so no same-cycle accept.
                    if (io.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_nibble_seq.sv
// Scoreboard bench for adder_nibble_seq: WIDTH=16 and WIDTH=4 instances with a behavioural 4-bit adder.
// Latency: checked as edges from accept to first edge seeing out_valid (NIB+1).
// Backpressure: out_ready held low to check result hold and busy-input rejection.
module tb_adder_nibble_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    adder_nibble_seq_if #(.WIDTH(16)) ifc16 ();
    adder_nibble_seq_if #(.WIDTH(4))  ifc4 ();

    logic [3:0] nib_a16, nib_b16, nib_a4, nib_b4;
    logic       nib_cin16, nib_cin4;
    logic [4:0] nib_res16, nib_res4;

    // Behavioural 4-bit ripple adder stage.
    assign nib_res16 = {1'b0, nib_a16} + {1'b0, nib_b16} + {4'b0, nib_cin16};
    assign nib_res4  = {1'b0, nib_a4} + {1'b0, nib_b4} + {4'b0, nib_cin4};

    adder_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .io(ifc16),
        .nib_a(nib_a16), .nib_b(nib_b16), .nib_cin(nib_cin16), .nib_res(nib_res16)
    );

    adder_nibble_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .io(ifc4),
        .nib_a(nib_a4), .nib_b(nib_b4), .nib_cin(nib_cin4), .nib_res(nib_res4)
    );

    typedef struct {
        logic [16:0] sum;
        int          acc;
    } exp_t;

    exp_t       q16[$];
    exp_t       q4[$];
    logic [3:0] a_log[$];
    logic       c_log[$];
    logic       ov16_prev = 1'b0;
    logic       ov4_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 16-bit instance: latency, result value/stability, busy in_ready, idle nibbles.
    always @(negedge clk) begin
        if (rst) begin
            ov16_prev = 1'b0;
        end else begin
            if (ifc16.out_valid) begin
                if (q16.size() == 0) begin
                    if (!ov16_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result16: got sum 0x%0h, required no output", ifc16.out_sum);
                    end
                end else begin
                    if (!ov16_prev) check("latency16", cyc + 1 - q16[0].acc, 5);
                    check("in_ready_busy16", {31'b0, ifc16.in_ready}, 0);
                    check("out_sum16", {15'b0, ifc16.out_sum}, {15'b0, q16[0].sum});
                    if (ifc16.out_ready) void'(q16.pop_front());
                end
            end else if (ifc16.in_ready) begin
                check("idle_nibbles16", {23'b0, nib_a16, nib_b16, nib_cin16}, 0);
            end
            ov16_prev = ifc16.out_valid;
        end
    end

    // Log the nibble bus during RUN cycles of the 16-bit instance.
    always @(negedge clk) begin
        if (!rst && !ifc16.in_ready && !ifc16.out_valid) begin
            a_log.push_back(nib_a16);
            c_log.push_back(nib_cin16);
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            ov4_prev = 1'b0;
        end else begin
            if (ifc4.out_valid) begin
                if (q4.size() == 0) begin
                    if (!ov4_prev) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result4: got sum 0x%0h, required no output", ifc4.out_sum);
                    end
                end else begin
                    if (!ov4_prev) check("latency4", cyc + 1 - q4[0].acc, 2);
                    check("out_sum4", {27'b0, ifc4.out_sum}, {15'b0, q4[0].sum});
                    if (ifc4.out_ready) void'(q4.pop_front());
                end
            end
            ov4_prev = ifc4.out_valid;
        end
    end

    // Present one transaction to the 16-bit instance; returns #1 after the accept edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [16:0] exp);
        int   n = 0;
        exp_t e;
        ifc16.in_valid = 1'b1;
        ifc16.in_a     = a;
        ifc16.in_b     = b;
        ifc16.in_cin   = cin;
        while (!ifc16.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait16", (n < 50) ? 1 : 0, 1);
        e.sum = exp;
        e.acc = cyc + 1;
        q16.push_back(e);
        @(posedge clk); #1;
        // Scramble operands after acceptance; the result must not depend on them.
        ifc16.in_valid = 1'b0;
        ifc16.in_a     = ~a;
        ifc16.in_b     = 16'h5A5A;
        ifc16.in_cin   = ~cin;
    endtask

    task automatic wait_done16();
        int n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain16", q16.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pack_a_log();
        logic [15:0] v = '0;
        foreach (a_log[i]) v = {v[11:0], a_log[i]};
        return v;
    endfunction

    function automatic logic [3:0] pack_c_log();
        logic [3:0] v = '0;
        foreach (c_log[i]) v = {v[2:0], c_log[i]};
        return v;
    endfunction

    initial begin
        int   n;
        exp_t e;
        ifc16.in_valid = 1'b0; ifc16.in_a = '0; ifc16.in_b = '0; ifc16.in_cin = 1'b0;
        ifc16.out_ready = 1'b1;
        ifc4.in_valid = 1'b0; ifc4.in_a = '0; ifc4.in_b = '0; ifc4.in_cin = 1'b0;
        ifc4.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready16", {31'b0, ifc16.in_ready}, 1);
        check("rst_out_valid16", {31'b0, ifc16.out_valid}, 0);
        check("rst_out_sum16", {15'b0, ifc16.out_sum}, 0);
        check("rst_in_ready4", {31'b0, ifc4.in_ready}, 1);
        check("rst_out_valid4", {31'b0, ifc4.out_valid}, 0);

        // Basic add and nibble order.
        a_log.delete(); c_log.delete();
        send16(16'h1234, 16'h4321, 1'b0, 17'h05555);
        wait_done16();
        check("nib_a_len", a_log.size(), 4);
        check("nib_a_seq", {16'b0, pack_a_log()}, 32'h4321);

        // Full carry ripple.
        a_log.delete(); c_log.delete();
        send16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        wait_done16();
        check("nib_cin_seq", {28'b0, pack_c_log()}, 32'h7);

        // Maximum operands with carry-in.
        send16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        wait_done16();

        // Backpressure with a competing request held on the input while busy.
        ifc16.out_ready = 1'b0;
        send16(16'h0F0F, 16'h00F1, 1'b0, 17'h01000);
        ifc16.in_valid = 1'b1;
        ifc16.in_a     = 16'hAAAA;
        ifc16.in_b     = 16'h1111;
        n = 0;
        while (!ifc16.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_wait", (n < 50) ? 1 : 0, 1);
        for (int i = 0; i < 6; i++) begin
            check("bp_in_ready", {31'b0, ifc16.in_ready}, 0);
            check("bp_hold_sum", {15'b0, ifc16.out_sum}, 32'h01000);
            @(posedge clk); #1;
        end
        ifc16.in_valid  = 1'b0;
        ifc16.out_ready = 1'b1;
        wait_done16();
        send16(16'h2345, 16'h1111, 1'b1, 17'h03457);
        wait_done16();

        // Reset during the second RUN cycle discards the transaction.
        send16(16'h1111, 16'h2222, 1'b0, 17'h03333);
        @(posedge clk); #1;
        rst = 1'b1;
        q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", {31'b0, ifc16.in_ready}, 1);
        check("midrst_out_valid", {31'b0, ifc16.out_valid}, 0);
        check("midrst_out_sum", {15'b0, ifc16.out_sum}, 0);
        send16(16'h00FF, 16'h0001, 1'b0, 17'h00100);
        wait_done16();

        // Single-nibble build.
        ifc4.in_valid = 1'b1;
        ifc4.in_a     = 4'hF;
        ifc4.in_b     = 4'h1;
        ifc4.in_cin   = 1'b1;
        n = 0;
        while (!ifc4.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        e.sum = 17'h00011;
        e.acc = cyc + 1;
        q4.push_back(e);
        @(posedge clk); #1;
        ifc4.in_valid = 1'b0;
        ifc4.in_a     = 4'h0;
        n = 0;
        while (q4.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain4", q4.size(), 0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
